// File: rtl/operand_loader.sv
// Byte-serial operand loader: assembles CTRL, A, B, C_lo and C_hi into pipe0 operands with a save strobe.
// Optional accumulate mode (C taken from the fed-back result) is compiled in with LOADER_ACC_EN.
module operand_loader (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        sync,
   input  logic        valid_in,
   input  logic [7:0]  data_in,
`ifdef LOADER_ACC_EN
   input  logic [15:0] acc_in,
   input  logic        acc_valid,
`endif
   output logic [7:0]  A,
   output logic [7:0]  B,
   output logic [15:0] C,
   output logic        Afmt,
   output logic        Bfmt,
   output logic        save,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_CTRL = 3'd0,
      S_A    = 3'd1,
      S_B    = 3'd2,
      S_CL   = 3'd3,
      S_CH   = 3'd4
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic        accept_s;
   logic        resync_s;
   logic        issue_s;
   logic        acc_frame_s;
   logic [15:0] issue_c_s;

   logic        stg_afmt_r;
   logic        stg_bfmt_r;
   logic [7:0]  stg_a_r;
   logic [7:0]  stg_b_r;
   logic [7:0]  stg_cl_r;

   // sync only takes effect while enabled, so ena low freezes everything
   assign resync_s = ena & sync;
   assign accept_s = ena & valid_in & ~sync;

`ifdef LOADER_ACC_EN
   logic        stg_acc_r;
   logic [15:0] acc_r;

   // Accumulator capture, independent of ena
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= 16'h0000;
      end else if (acc_valid) begin
         acc_r <= acc_in;
      end
   end

   // Accumulate-frame flag captured with CTRL, cleared by resync
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_acc_r <= 1'b0;
      end else if (resync_s) begin
         stg_acc_r <= 1'b0;
      end else if (accept_s && (state_r == S_CTRL)) begin
         stg_acc_r <= data_in[2];
      end
   end

   // Issue C: a result arriving in the issue cycle bypasses the register
   always_comb begin
      acc_frame_s = stg_acc_r;
      if (acc_frame_s) begin
         issue_c_s = acc_valid ? acc_in : acc_r;
      end else begin
         issue_c_s = {data_in, stg_cl_r};
      end
   end
`else
   // Without accumulate support every frame carries its own addend
   always_comb begin
      acc_frame_s = 1'b0;
      issue_c_s   = {data_in, stg_cl_r};
   end
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_CTRL;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and issue decode; one transition per accepted byte
   always_comb begin
      next_state_s = state_r;
      issue_s      = 1'b0;
      if (resync_s) begin
         next_state_s = S_CTRL;
      end else if (accept_s) begin
         case (state_r)
            S_CTRL: next_state_s = S_A;
            S_A:    next_state_s = S_B;
            S_B: begin
               if (acc_frame_s) begin
                  next_state_s = S_CTRL;
                  issue_s      = 1'b1;
               end else begin
                  next_state_s = S_CL;
               end
            end
            S_CL:   next_state_s = S_CH;
            S_CH: begin
               next_state_s = S_CTRL;
               issue_s      = 1'b1;
            end
            default: next_state_s = S_CTRL;
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   // Staging registers, one per frame field
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_afmt_r <= 1'b0;
         stg_bfmt_r <= 1'b0;
         stg_a_r    <= 8'h00;
         stg_b_r    <= 8'h00;
         stg_cl_r   <= 8'h00;
      end else if (resync_s) begin
         stg_afmt_r <= 1'b0;
         stg_bfmt_r <= 1'b0;
         stg_a_r    <= 8'h00;
         stg_b_r    <= 8'h00;
         stg_cl_r   <= 8'h00;
      end else if (accept_s) begin
         case (state_r)
            S_CTRL: begin
               stg_afmt_r <= data_in[0];
               stg_bfmt_r <= data_in[1];
            end
            S_A:     stg_a_r  <= data_in;
            S_B:     stg_b_r  <= data_in;
            S_CL:    stg_cl_r <= data_in;
            default: ;
         endcase
      end
   end

   // Output registers load only on issue; the final byte is taken straight from data_in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A    <= 8'h00;
         B    <= 8'h00;
         C    <= 16'h0000;
         Afmt <= 1'b0;
         Bfmt <= 1'b0;
      end else if (issue_s) begin
         A    <= stg_a_r;
         B    <= (state_r == S_B) ? data_in : stg_b_r;
         C    <= issue_c_s;
         Afmt <= stg_afmt_r;
         Bfmt <= stg_bfmt_r;
      end
   end

   // Strobe and busy flag, registered from the decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         save <= 1'b0;
         busy <= 1'b0;
      end else begin
         save <= issue_s;
         busy <= (next_state_s != S_CTRL);
      end
   end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: stimulus pushes expected issues, a monitor checks each save pulse.
module tb_operand_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic        sync = 1'b0;
   logic        valid_in = 1'b0;
   logic [7:0]  data_in = 8'h00;
`ifdef LOADER_ACC_EN
   logic [15:0] acc_in = 16'h0000;
   logic        acc_valid = 1'b0;
`endif
   logic [7:0]  A, B;
   logic [15:0] C;
   logic        Afmt, Bfmt, save, busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] c;
      logic        af;
      logic        bf;
      int          at;
   } exp_t;
   exp_t sb_q[$];

   logic [33:0] prev_out = 34'd0;

   operand_loader dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sync(sync),
      .valid_in(valid_in), .data_in(data_in),
`ifdef LOADER_ACC_EN
      .acc_in(acc_in), .acc_valid(acc_valid),
`endif
      .A(A), .B(B), .C(C), .Afmt(Afmt), .Bfmt(Bfmt), .save(save), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every save pops one expected issue; outputs must hold between pulses
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_out = {A, B, C, Afmt, Bfmt};
      end else if (save) begin
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_save cycle=%0d A=%h B=%h C=%h", cyc, A, B, C);
         end else begin
            e = sb_q.pop_front();
            if (A !== e.a || B !== e.b || C !== e.c || Afmt !== e.af || Bfmt !== e.bf || cyc != e.at) begin
               fails++;
               $display("FAIL issue got A=%h B=%h C=%h Af=%b Bf=%b cyc=%0d want A=%h B=%h C=%h Af=%b Bf=%b cyc=%0d",
                        A, B, C, Afmt, Bfmt, cyc, e.a, e.b, e.c, e.af, e.bf, e.at);
            end
         end
      end else begin
         tests++;
         if ({A, B, C, Afmt, Bfmt} !== prev_out) begin
            fails++;
            $display("FAIL hold_between_saves got %h want %h cycle=%0d", {A, B, C, Afmt, Bfmt}, prev_out, cyc);
         end
      end
      prev_out = {A, B, C, Afmt, Bfmt};
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = d;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   // Expected issue is due one cycle after the byte just driven
   task automatic expect_issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c,
                               input logic af, input logic bf);
      exp_t e;
      e.a = a; e.b = b; e.c = c; e.af = af; e.bf = bf; e.at = cyc + 1;
      sb_q.push_back(e);
   endtask

   task automatic frame5(input logic [7:0] ctl, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] cl, input logic [7:0] ch);
      send(ctl); send(a); send(b); send(cl); send(ch);
      expect_issue(a, b, {ch, cl}, ctl[0], ctl[1]);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      repeat (20) begin
         @(negedge clk);
         check("reset_idle", {save, busy, A, B, C, Afmt, Bfmt}, 32'h0);
      end

      // Basic frame
      frame5(8'h03, 8'h38, 8'h38, 8'h00, 8'h3C);
      gap(4);

      // Back-to-back: second CTRL lands in the save cycle
      frame5(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
      frame5(8'h02, 8'h55, 8'h66, 8'h77, 8'h88);
      gap(4);

      // Resync mid-frame drops the byte presented with sync
      send(8'h00); send(8'h3C);
      @(negedge clk);
      check("busy_before_sync", {31'd0, busy}, 32'd1);
      sync = 1'b1; valid_in = 1'b1; data_in = 8'h11;
      @(negedge clk);
      sync = 1'b0; valid_in = 1'b0;
      check("busy_after_sync", {31'd0, busy}, 32'd0);
      gap(2);
      frame5(8'h02, 8'h12, 8'h34, 8'h78, 8'h56);
      gap(3);

      // ena low holds the frame; bytes offered meanwhile are ignored
      send(8'h00); send(8'hAA);
      @(negedge clk);
      ena = 1'b0; valid_in = 1'b1; data_in = 8'h55;
      repeat (3) @(negedge clk);
      check("busy_ena_hold", {31'd0, busy}, 32'd1);
      ena = 1'b1; data_in = 8'hBB;
      send(8'hCD); send(8'hAB);
      expect_issue(8'hAA, 8'hBB, 16'hABCD, 1'b0, 1'b0);
      gap(3);

      // Gappy frame with ignored high CTRL bits
      send(8'hF8); gap(2); send(8'h21); gap(1); send(8'h43); send(8'h65); gap(3); send(8'h87);
      expect_issue(8'h21, 8'h43, 16'h8765, 1'b0, 1'b0);
      gap(3);

      // Reset mid-frame
      send(8'h03); send(8'h99);
      @(negedge clk);
      valid_in = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_mid_frame", {save, busy, A, B, C, Afmt, Bfmt}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      gap(2);
      check("busy_after_reset", {31'd0, busy}, 32'd0);

`ifdef LOADER_ACC_EN
      // Accumulate from the captured result
      @(negedge clk);
      valid_in = 1'b0; acc_valid = 1'b1; acc_in = 16'h4000;
      @(negedge clk);
      acc_valid = 1'b0;
      send(8'h04); send(8'h3C); send(8'h3C);
      expect_issue(8'h3C, 8'h3C, 16'h4000, 1'b0, 1'b0);
      gap(3);

      // Bypass: fresh result in the issue cycle wins
      send(8'h07); send(8'h3C); send(8'hBC);
      acc_valid = 1'b1; acc_in = 16'h4200;
      expect_issue(8'h3C, 8'hBC, 16'h4200, 1'b1, 1'b1);
      @(negedge clk);
      acc_valid = 1'b0; valid_in = 1'b0;
      gap(3);
`else
      // CTRL bit2 has no effect: still a 5-byte frame
      frame5(8'hFE, 8'h40, 8'hC0, 8'h00, 8'h3C);
      gap(3);
`endif

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL missing_save got %0d pending want 0", sb_q.size());
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/operand_loader.md
# operand_loader

Byte-serial front end for the FP8×FP8+FP16 multiply-accumulate pipeline. Accepts one 8-bit byte per cycle from the chip input pins, assembles a control byte, operands A and B, and 16-bit addend C, then presents them to the multiply stage (pipe0) with a one-cycle `save` strobe. An optional accumulate mode replaces C with the previously captured pipeline result, so dot products can run without reloading the addend.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global enable; when low, no byte is accepted and state holds.
- `sync`  in  1  framing resync; discards partial frame.
- `valid_in`  in  1  `data_in` carries a byte this cycle.
- `data_in`  in  8  serial byte.
- `acc_in`  in  16  FP16 result fed back from the final sum stage.
- `acc_valid`  in  1  `acc_in` holds a fresh result to capture.
- `A`  out  8  FP8 operand A, to pipe0.
- `B`  out  8  FP8 operand B, to pipe0.
- `C`  out  16  FP16 addend, to pipe0.
- `Afmt`  out  1  1 = E4M3, 0 = E5M2.
- `Bfmt`  out  1  same encoding as `Afmt`.
- `save`  out  1  one-cycle issue strobe, to pipe0.
- `busy`  out  1  high while a frame is partially received.

## Operation
- A byte is accepted when `ena && valid_in && !sync`.
- Frame order: CTRL, A, B, C_lo, C_hi.
  - CTRL bit0 = Afmt, bit1 = Bfmt, bit2 = acc. Bits[7:3] are ignored.
- FSM states and transitions, one per accepted byte:
  - S_CTRL → S_A → S_B
  - S_B → S_CL → S_CH → S_CTRL, when acc = 0
  - S_B → S_CTRL, when acc = 1; C is taken from the accumulator register.
- Bytes are captured into staging registers. Output registers A/B/C/Afmt/Bfmt load from staging only on issue, and hold between issues.
- Issue is the acceptance of the final byte of a frame (C_hi, or B when acc = 1).
  - Cycle after issue: outputs carry the new frame and `save` = 1 for exactly one cycle.
- Accumulator register: 16 bits, loads `acc_in` on any cycle with `acc_valid` = 1, independent of `ena`.
  - If `acc_valid` is high in the issue cycle, the issue uses the new `acc_in` value (bypass).
- `busy` = 1 in S_A, S_B, S_CL, S_CH.
- `sync` = 1: next state is S_CTRL and staging is cleared to 0. It has priority over a same-cycle valid byte, which is dropped. `sync` never produces `save` and never alters the output registers.
- `ena` = 0: FSM, staging and outputs hold. A pending `save` still deasserts after its one cycle.

## Timing
- Reset values: A = 0x00, B = 0x00, C = 0x0000, Afmt = 0, Bfmt = 0, `save` = 0, `busy` = 0. FSM = S_CTRL, accumulator = 0x0000.
- Latency: 5 bytes (acc = 0) or 3 bytes (acc = 1) from CTRL to issue; `save` appears 1 cycle after the final byte.
- Back-to-back frames: a CTRL byte may be accepted in the same cycle `save` is high. There is no bubble. Peak throughput is one issue per 3 or 5 cycles.
- Reset asserted mid-frame returns immediately to reset values. The partial frame is lost and `save` is forced low asynchronously.
- A `valid_in` gap between bytes is legal and of any length; the FSM waits.

## Configuration
- `LOADER_ACC_EN` defined:
  - accumulate mode, `acc_in`/`acc_valid` ports and the accumulator register are present;
  - CTRL bit2 is honoured.
- `LOADER_ACC_EN` undefined:
  - ports `acc_in`/`acc_valid` are absent and the accumulator register is removed;
  - CTRL bit2 is ignored, so every frame is 5 bytes and C always comes from C_lo/C_hi.

## Test plan
- Reset, then idle: all outputs at reset values, `save` = 0 for 20 cycles.
- Frame 0x03, 0x38, 0x38, 0x00, 0x3C, one byte per cycle → one cycle after C_hi: A = 0x38, B = 0x38, C = 0x3C00, Afmt = 1, Bfmt = 1, `save` = 1 for exactly 1 cycle.
- Two frames back-to-back, with the second CTRL accepted in the `save` cycle → two `save` pulses exactly 5 cycles apart. Outputs change only on the pulses.
- Send 0x00, 0x3C, then assert `sync` with `valid_in` = 1 and data 0x11 → FSM returns to S_CTRL, `busy` = 0, no `save`, 0x11 is dropped. A following full frame issues correctly.
- Accumulate mode (`LOADER_ACC_EN`): pulse `acc_valid` with `acc_in` = 0x4000, then send 0x04, 0x3C, 0x3C → `save` after the third byte, with C = 0x4000 and Afmt = Bfmt = 0.
- Accumulate bypass: `acc_valid` with `acc_in` = 0x4200 in the same cycle as B is accepted → the issued C = 0x4200.
